// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b11
  } fwd_sel_t;

  typedef enum logic [1:0] {
    IDLE,
    MISS,
    RESUME
  } miss_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/fwd_sel_unit.sv
// Forwarding select for one execute-stage operand; the memory stage wins
// over writeback because it holds the younger result.
module fwd_sel_unit
  import hazard_pkg::*;
(
  input  logic [4:0] rs_e_i,
  input  logic [4:0] rd_m_i,
  input  logic [4:0] rd_w_i,
  input  logic       regwrite_m_i,
  input  logic       regwrite_w_i,
  output fwd_sel_t   sel_o
);

  always_comb begin
    sel_o = FWD_REG;
    if (regwrite_m_i && (rd_m_i != REG_ZERO) && (rd_m_i == rs_e_i)) begin
      sel_o = FWD_MEM;
    end else if (regwrite_w_i && (rd_w_i != REG_ZERO) && (rd_w_i == rs_e_i)) begin
      sel_o = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: operand forwarding, load-use stalls, branch
// flushes and a data-cache miss freeze with miss/stall counters.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int CNT_W      = 32,
  parameter int MISS_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4:0]            rs1_d,
  input  logic [4:0]            rs2_d,
  input  logic [4:0]            rs1_e,
  input  logic [4:0]            rs2_e,
  input  logic [4:0]            rd_e,
  input  logic                  memread_e,
  input  logic                  pcsrc_e,
  input  logic [4:0]            rd_m,
  input  logic [4:0]            rd_w,
  input  logic                  regwrite_m,
  input  logic                  regwrite_w,
  input  logic                  dreq_m,
  input  logic                  dhit_m,
  input  logic                  refill_done,
  output logic [1:0]            forward_a_e,
  output logic [1:0]            forward_b_e,
  output logic                  stall_f,
  output logic                  stall_d,
  output logic                  stall_e,
  output logic                  stall_m,
  output logic                  flush_d,
  output logic                  flush_e,
  output logic                  flush_w,
  output logic                  miss_busy,
  output logic [MISS_CNT_W-1:0] miss_cnt,
  output logic [CNT_W-1:0]      stall_cycles
);

  fwd_sel_t        fwd_a, fwd_b;
  miss_state_t     state_q, state_d;
  logic            miss_detect, missstall, lwstall;
  logic [MISS_CNT_W-1:0] miss_cnt_q, miss_cnt_d;
  logic [CNT_W-1:0]      stall_cycles_q, stall_cycles_d;

  fwd_sel_unit u_fwd_a (
    .rs_e_i       (rs1_e),
    .rd_m_i       (rd_m),
    .rd_w_i       (rd_w),
    .regwrite_m_i (regwrite_m),
    .regwrite_w_i (regwrite_w),
    .sel_o        (fwd_a)
  );

  fwd_sel_unit u_fwd_b (
    .rs_e_i       (rs2_e),
    .rd_m_i       (rd_m),
    .rd_w_i       (rd_w),
    .regwrite_m_i (regwrite_m),
    .regwrite_w_i (regwrite_w),
    .sel_o        (fwd_b)
  );

  assign forward_a_e = fwd_a;
  assign forward_b_e = fwd_b;

  assign lwstall     = memread_e && (rd_e != REG_ZERO) && ((rd_e == rs1_d) || (rd_e == rs2_d));
  assign miss_detect = (state_q == IDLE) && dreq_m && !dhit_m;
  assign missstall   = miss_detect || (state_q != IDLE);

  // A miss freeze holds E, so branch and load-use flushes are deferred until release.
  assign stall_f   = lwstall || missstall;
  assign stall_d   = lwstall || missstall;
  assign stall_e   = missstall;
  assign stall_m   = missstall;
  assign flush_w   = missstall;
  assign flush_d   = pcsrc_e && !missstall;
  assign flush_e   = (lwstall || pcsrc_e) && !missstall;
  assign miss_busy = missstall;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (miss_detect) state_d = MISS;
      MISS:    if (refill_done) state_d = RESUME;
      RESUME:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    miss_cnt_d     = miss_cnt_q;
    stall_cycles_d = stall_cycles_q;
    if (miss_detect && (miss_cnt_q != {MISS_CNT_W{1'b1}})) begin
      miss_cnt_d = miss_cnt_q + MISS_CNT_W'(1);
    end
    if (missstall && (stall_cycles_q != {CNT_W{1'b1}})) begin
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      miss_cnt_q     <= '0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      miss_cnt_q     <= miss_cnt_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign miss_cnt     = miss_cnt_q;
  assign stall_cycles = stall_cycles_q;

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard controller for the pipelined-plus-cache core. It drives the 2-bit select lines of the two execute-stage operand forwarding muxes, detects load-use hazards, flushes on taken branches/jumps, and freezes the pipeline during data-cache misses under a small state machine. It sits beside the datapath, takes register indices and control bits from the D/E/M/W stages plus the data-cache hit/refill status, and returns stall/flush enables to every pipeline register. It also keeps miss-count and stall-cycle counters.

## Interface
Parameters:
- CNT_W, 32, width of the stall-cycle counter.
- MISS_CNT_W, 16, width of the miss counter.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- rs1_d, rs2_d  in  5  source registers in decode.
- rs1_e, rs2_e, rd_e  in  5  source and destination registers in execute.
- memread_e  in  1  execute instruction is a load.
- pcsrc_e  in  1  branch taken or jump resolved in execute.
- rd_m, rd_w  in  5  destinations in memory and writeback.
- regwrite_m, regwrite_w  in  1  register-write enables.
- dreq_m  in  1  valid load/store in memory stage.
- dhit_m  in  1  data-cache hit for dreq_m.
- refill_done  in  1  single-cycle pulse when the line fill completes.
- forward_a_e, forward_b_e  out  2  operand mux selects.
- stall_f, stall_d, stall_e, stall_m  out  1  hold the corresponding pipeline register.
- flush_d, flush_e, flush_w  out  1  insert a bubble into the corresponding register.
- miss_busy  out  1  high while the miss FSM is active (the detection cycle included).
- miss_cnt  out  MISS_CNT_W  misses taken.
- stall_cycles  out  CNT_W  cycles stalled due to misses.

## Operation
- Forward select encoding: 2'b00 register file, 2'b01 writeback result, 2'b11 memory-stage ALU result. 2'b10 is never driven.
- forward_a_e selection, in priority order:
  - 11 if regwrite_m, rd_m != 0 and rd_m == rs1_e;
  - else 01 if regwrite_w, rd_w != 0 and rd_w == rs1_e;
  - else 00.
  - forward_b_e uses the same rules with rs2_e.
- Load-use: lwstall = memread_e & (rd_e != 0) & (rd_e == rs1_d | rd_e == rs2_d). It raises stall_f, stall_d and flush_e.
- Branch: pcsrc_e raises flush_d and flush_e.
- Miss FSM states: IDLE, MISS, RESUME.
  - IDLE→MISS when dreq_m & ~dhit_m.
  - MISS→RESUME on refill_done.
  - RESUME→IDLE unconditionally.
- missstall = (IDLE & dreq_m & ~dhit_m) | MISS | RESUME. It raises stall_f, stall_d, stall_e, stall_m and flush_w.
- Priority: missstall masks lwstall-driven flush_e and all branch flushes. The frozen E stage re-presents pcsrc_e/memread_e after release, so those hazards are then handled normally.
- lwstall and pcsrc_e together: flush_d, flush_e, stall_f, stall_d all asserted.
- Counters:
  - miss_cnt increments on every IDLE→MISS transition.
  - stall_cycles increments on every cycle with missstall.
  - Both counters saturate at all-ones and do not wrap.

## Timing
- Forward selects, stalls and flushes are combinational from the inputs and FSM state, valid in the same cycle.
- Reset values: FSM IDLE, miss_cnt 0, stall_cycles 0. Every output is 0 under rst with all inputs 0.
- Miss penalty is N+2 stall cycles, where N = cycles spent in MISS including the refill_done cycle: the detection cycle, then the MISS cycles, then one RESUME cycle during which the cache re-reads and delivers hit data.
- refill_done arriving in IDLE or RESUME is ignored.
- rst asserted mid-miss: FSM returns to IDLE immediately and the counters clear.

## Structure
- hazard_pkg holds:
  - fwd_sel_t: FWD_REG=2'b00, FWD_WB=2'b01, FWD_MEM=2'b11;
  - miss_state_t: IDLE, MISS, RESUME;
  - REG_ZERO = 5'd0.
- One sub-module, fwd_sel_unit, computes one operand's select. It is instantiated twice, for rs1_e and rs2_e.

## Test plan
- rd_m=5, regwrite_m=1, rd_w=5, regwrite_w=1, rs1_e=5 → forward_a_e=11 (M priority). Then regwrite_m=0 → 01. Then rd_m=rd_w=0, rs1_e=0 → 00.
- memread_e=1, rd_e=7, rs2_d=7 → stall_f=stall_d=flush_e=1 for one cycle. With rd_e=0 → no stall.
- dreq_m=1, dhit_m=0, refill_done 3 cycles later → stall_m high for 5 consecutive cycles, miss_cnt=1, stall_cycles=5.
- pcsrc_e=1 during MISS → flush_d=flush_e=0 while stalled. Once pcsrc_e is re-presented after RESUME → flush_d=flush_e=1.
- rst pulsed while in MISS → miss_busy=0, all stalls 0, counters 0 asynchronously. Next cycle with dhit_m=1 → no stall.
- stall_cycles forced near saturation: 3 more stall cycles from 32'hFFFFFFFE → holds 32'hFFFFFFFF.
